// File: rtl/udp_tx_arb.sv
// Frame-granular round-robin arbiter merging Nsrc byte-wide AXI-Stream payload sources onto udp_tx.
// Optional per-source frame/truncation counters are enabled by defining UDP_TX_ARB_STATS_EN.
module udp_tx_arb #(
    parameter int Nsrc    = 2,
    parameter int MAX_LEN = 1472
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Nsrc-1:0]      s_tvalid,
    output logic [Nsrc-1:0]      s_tready,
    input  logic [Nsrc-1:0][7:0] s_tdata,
    input  logic [Nsrc-1:0]      s_tlast,
    input  logic [Nsrc-1:0]      s_tuser,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic [Nsrc-1:0]      grant,
    output logic                 busy
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [Nsrc-1:0][15:0] frame_cnt,
    output logic [Nsrc-1:0][15:0] trunc_cnt
`endif
);

    localparam int IDX_W = (Nsrc > 1) ? $clog2(Nsrc) : 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DRAIN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;

    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_user;
    logic             at_limit;
    logic             force_trunc;

    // Round-robin scan starting just after the previous owner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= Nsrc; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % Nsrc);
            if (!pick_found && s_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign sel_valid   = s_tvalid[g_idx];
    assign sel_data    = s_tdata[g_idx];
    assign sel_last    = s_tlast[g_idx];
    assign sel_user    = s_tuser[g_idx];
    assign at_limit    = (beat_cnt == CNT_W'(MAX_LEN - 1));
    assign force_trunc = at_limit && !sel_last;

    // Data path is combinational so the owner sees udp_stack backpressure in the same cycle.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = '0;
        case (state)
            PASS: begin
                m_tvalid = sel_valid;
                m_tdata  = sel_data;
                m_tlast  = sel_last || at_limit;
                m_tuser  = sel_user || force_trunc;
                s_tready = grant & {Nsrc{m_tready}};
            end
            DRAIN: s_tready = grant;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            g_idx    <= '0;
            rr_ptr   <= IDX_W'(Nsrc - 1);
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= Nsrc'(1) << pick_idx;
                        g_idx <= pick_idx;
                        state <= PASS;
                        busy  <= 1'b1;
                    end
                end
                PASS: begin
                    if (m_tvalid && m_tready) begin
                        if (m_tlast) begin
                            beat_cnt <= '0;
                            if (force_trunc) begin
                                state <= DRAIN;
                            end else begin
                                state  <= IDLE;
                                rr_ptr <= g_idx;
                                grant  <= '0;
                                busy   <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The rest of a truncated frame is swallowed; ownership ends on its real tlast.
                    if (sel_valid && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= g_idx;
                        grant  <= '0;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_TX_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: counter arrays are reset explicitly; software reads them as absolute values.
            frame_cnt <= '0;
            trunc_cnt <= '0;
        end else if (state == PASS && m_tvalid && m_tready && m_tlast) begin
            frame_cnt[g_idx] <= frame_cnt[g_idx] + 16'd1;
            if (force_trunc) begin
                trunc_cnt[g_idx] <= trunc_cnt[g_idx] + 16'd1;
            end
        end
    end
`endif

endmodule
